// File: rtl/bch_pkg.sv
// Shared definitions for the BCH corrector: code selects, frame geometry helpers and FSM states.
package bch_pkg;

   localparam logic [1:0] CODE_63   = 2'd1;
   localparam logic [1:0] CODE_255  = 2'd2;
   localparam logic [1:0] CODE_1023 = 2'd3;

   typedef enum logic [1:0] {IDLE, LOAD, WAIT_LOC, DRAIN} state_t;

   function automatic int unsigned words_for_code(input logic [1:0] code);
      case (code)
         CODE_1023: return 16;
         CODE_255:  return 4;
         default:   return 1;
      endcase
   endfunction

   function automatic int unsigned n_for_code(input logic [1:0] code);
      case (code)
         CODE_1023: return 1023;
         CODE_255:  return 255;
         default:   return 63;
      endcase
   endfunction

endpackage

// File: rtl/corr_buf.sv
// Codeword buffer: one word write port, one single-bit toggle port, one combinational read port.
module corr_buf #(
   parameter int unsigned MAX_WORDS = 16,
   parameter int unsigned AW        = $clog2(MAX_WORDS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [63:0]   wdata,
   input  logic          fe,
   input  logic [AW-1:0] fword,
   input  logic [5:0]    fbit,
   input  logic [AW-1:0] raddr,
   output logic [63:0]   rdata
);

   logic [63:0] mem [MAX_WORDS];

   // Contents are not reset; writes are only held off while rst is high.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (we) begin
            mem[waddr] <= wdata;
         end else if (fe) begin
            mem[fword][fbit] <= ~mem[fword][fbit];
         end
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/bch_corrector.sv
// Buffers a received BCH codeword, flips the bits named by the decoder's location stream and
// streams the corrected words out over a valid/ready handshake.
module bch_corrector
   import bch_pkg::*;
#(
   parameter int unsigned MAX_WORDS = 16,
   parameter int unsigned LOC_W     = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             set,
   input  logic [1:0]       code,
   input  logic             cw_valid,
   input  logic [63:0]      cw_data,
   input  logic             loc_valid,
   input  logic [LOC_W-1:0] loc,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [63:0]      out_data,
   output logic             out_last,
   output logic             busy,
   output logic             err_flag
);

   localparam int unsigned AW = $clog2(MAX_WORDS);

   state_t        state_q, state_d;
   logic [1:0]    code_q, code_d;
   logic [AW-1:0] wcnt_q, wcnt_d;
   logic [AW-1:0] rcnt_q, rcnt_d;
   logic          err_q, err_d;
   logic          seen_q, seen_d;

   logic          buf_we;
   logic          flip_en;
   logic [AW-1:0] flip_word;
   logic [5:0]    flip_bit;
   logic [63:0]   rd_word;
   logic [AW-1:0] nw_last;
   logic          in_range;

   assign nw_last   = AW'(words_for_code(code_q) - 1);
   assign in_range  = (32'(loc) < n_for_code(code_q));
   // Position 64*k + (63-b) lives in word k, bit b.
   assign flip_word = loc[LOC_W-1:6];
   assign flip_bit  = 6'd63 - loc[5:0];

   corr_buf #(
      .MAX_WORDS (MAX_WORDS)
   ) u_buf (
      .clk   (clk),
      .rst   (rst),
      .we    (buf_we),
      .waddr (wcnt_q),
      .wdata (cw_data),
      .fe    (flip_en),
      .fword (flip_word),
      .fbit  (flip_bit),
      .raddr (rcnt_q),
      .rdata (rd_word)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         code_q  <= CODE_63;
         wcnt_q  <= '0;
         rcnt_q  <= '0;
         err_q   <= 1'b0;
         seen_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         wcnt_q  <= wcnt_d;
         rcnt_q  <= rcnt_d;
         err_q   <= err_d;
         seen_q  <= seen_d;
      end
   end

   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      wcnt_d  = wcnt_q;
      rcnt_d  = rcnt_q;
      err_d   = err_q;
      seen_d  = seen_q;
      buf_we  = 1'b0;
      flip_en = 1'b0;

      if (set) begin
         // A new frame start aborts whatever is in progress.
         state_d = LOAD;
         code_d  = (code == 2'd0) ? CODE_63 : code;
         err_d   = (code == 2'd0);
         wcnt_d  = '0;
         rcnt_d  = '0;
         seen_d  = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: ;
            LOAD: begin
               if (cw_valid) begin
                  buf_we = 1'b1;
                  wcnt_d = wcnt_q + 1'b1;
                  if (wcnt_q == nw_last) begin
                     state_d = WAIT_LOC;
                  end
               end
               if (loc_valid) begin
                  err_d = 1'b1;
               end
            end
            WAIT_LOC: begin
               if (loc_valid) begin
                  seen_d = 1'b1;
                  if (in_range) begin
                     flip_en = 1'b1;
                  end else begin
                     err_d = 1'b1;
                  end
               end else if (seen_q) begin
                  state_d = DRAIN;
               end
            end
            DRAIN: begin
               if (out_ready) begin
                  if (rcnt_q == nw_last) begin
                     state_d = IDLE;
                     rcnt_d  = '0;
                  end else begin
                     rcnt_d = rcnt_q + 1'b1;
                  end
               end
            end
         endcase
      end
   end

   assign busy      = (state_q != IDLE);
   assign out_valid = (state_q == DRAIN);
   assign out_data  = out_valid ? rd_word : '0;
   assign out_last  = out_valid && (rcnt_q == nw_last);
   assign err_flag  = err_q;

endmodule

// File: doc/bch_corrector.md
Name: bch_corrector

Overview:
- Downstream companion to the bch decoder.
- Captures the same 64-bit received codeword words the decoder consumes, then applies the decoder's error-location stream (odata while finish is high) by flipping the addressed bits.
- Streams the corrected codeword out as 64-bit words with a valid/ready handshake.
- Sits between the decoder and the host/sink; the decoder itself is untouched.

Parameters:
- MAX_WORDS, 16, buffer depth in 64-bit words; 16 covers n=1023.
- LOC_W, 10, width of an error location.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- set  input  1  frame start; same strobe as the decoder's set.
- code  input  2  code select, sampled on set: 1=n63 (1 word), 2=n255 (4 words), 3=n1023 (16 words).
- cw_valid  input  1  codeword word valid; driven from the decoder's ready.
- cw_data  input  64  codeword word; same value as the decoder's idata.
- loc_valid  input  1  error location valid; driven from the decoder's finish.
- loc  input  10  error location; driven from the decoder's odata.
- out_ready  input  1  sink accepts out_data.
- out_valid  output  1  corrected word valid.
- out_data  output  64  corrected word.
- out_last  output  1  high with the final word of the frame.
- busy  output  1  high in any state other than IDLE.
- err_flag  output  1  sticky per frame: a location was out of range or arrived early.

Behaviour:
- Reset (rst high at a clock edge): state to IDLE; out_valid, out_last, busy and err_flag go to 0; out_data goes to 0; word and read counters clear. Buffer contents are don't-care. rst wins over every other input.
- Bit mapping: word k, bit b (63=MSB) holds codeword position p = 64*k + (63-b). Word 0 arrives first. Location L flips word L[9:6], bit 63-L[5:0].
- Valid range is L < n: 63, 255 or 1023 for code 1/2/3. A location with L >= n is dropped and sets err_flag.
- code = 0 on set: the frame is handled as code 1 and err_flag is set.
- IDLE: on set, latch code, clear err_flag and counters, go to LOAD.
- LOAD: each cycle with cw_valid high, write cw_data to buf[wcnt] and increment wcnt. After word NW-1 (NW = 1/4/16), go to WAIT_LOC. Extra cw_valid cycles outside LOAD are ignored.
- loc_valid high during LOAD: the location is dropped and err_flag is set.
- WAIT_LOC: each cycle with loc_valid high and L in range, flip one bit (read-modify-write, one flip per cycle, takes effect next cycle).
  - Duplicate locations flip twice, which restores the bit.
  - On the first cycle loc_valid is low after having been high in this state, go to DRAIN. A WAIT_LOC that never saw loc_valid stays in WAIT_LOC.
- DRAIN: out_valid = 1, out_data = buf[rcnt], out_last = (rcnt == NW-1).
  - rcnt advances only when out_valid && out_ready.
  - out_data and out_last hold stable while out_ready is low.
  - After the last word is accepted, go to IDLE; out_valid is 0 in the following cycle.
- First word: out_valid first asserts in the cycle after the WAIT_LOC→DRAIN transition, so it reflects all flips.
- set while not IDLE: abort the current frame and restart LOAD with the new code. out_valid drops the same edge.
- Simultaneous set and rst: rst wins.
- Latency: first out_valid is 1 cycle after loc_valid falls. Drain takes NW cycles at out_ready=1.

Decomposition:
- Shared package bch_pkg:
  - code constants CODE_63=1, CODE_255=2, CODE_1023=3;
  - function words_for_code(code) → 1/4/16;
  - function n_for_code(code) → 63/255/1023;
  - state enum IDLE/LOAD/WAIT_LOC/DRAIN.
- One natural sub-module: corr_buf.
  - MAX_WORDS x 64 register file.
  - One write port (load), one bit-flip port (word index, bit index, enable), one read port (combinational).
  - Same clk/rst, no reset of contents.

Test Plan:
1. code=1, one word 64'h0, locations {0,5} → out_data 64'h8400_0000_0000_0000, out_last=1 on the single word, err_flag=0.
2. code=2, 4 words all 64'hFFFF_FFFF_FFFF_FFFF, locations {64,255} → word1 = 64'h7FFF_FFFF_FFFF_FFFF, word3 = 64'hFFFF_FFFF_FFFF_FFFE, words 0 and 2 unchanged, out_last only on word3.
3. code=3, 16 words of 0, locations {1022,1022,300} → only word4 bit 19 set (64'h0000_0000_0008_0000), duplicate cancelled; code=1 with loc=63 → dropped, err_flag=1, word unchanged.
4. code=2, drain with out_ready toggling 1,0,0,1,… → each word presented exactly once, out_data stable during stall cycles, 4 accepted words in order.
5. set reasserted mid-LOAD (after 2 of 4 words) with code=1 → out_valid stays 0, new frame loads 1 word and drains correctly; rst pulsed during DRAIN → next-cycle out_valid=0, busy=0, err_flag=0.
6. loc_valid pulsed during LOAD (code=2) → location dropped, err_flag=1, data otherwise corrected per later locations.
